ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, instruction address width (word-addressed).
REQ-002 SHALL have parameter DATA_W, default 24, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 24'h000000, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port iaddr  output  ADDR_W  instruction memory address, valid when ireq=1.
REQ-007 SHALL have port ireq  output  1  fetch request to instruction memory.
REQ-008 SHALL have port idata  input  DATA_W  memory read data, valid exactly 1 cycle after ireq=1.
REQ-009 SHALL have port instr_valid  output  1  instr_data/instr_pc hold a valid instruction for decode.
REQ-010 SHALL have port instr_ready  input  1  decode accepts the instruction this cycle.
REQ-011 SHALL have port instr_data  output  DATA_W  instruction word at queue head.
REQ-012 SHALL have port instr_pc  output  ADDR_W  address the head instruction was fetched from.
REQ-013 SHALL have port redirect_valid  input  1  move to PC (R31) executed; restart fetch.
REQ-014 SHALL have port redirect_pc  input  ADDR_W  new PC value, sampled when redirect_valid=1.
REQ-015 SHALL have port halt  input  1  stop issuing new fetches (level).
REQ-016 SHALL have port pc_out  output  ADDR_W  next address to be fetched (architectural PC for the R31 read path).

Function
REQ-017 SHALL implement states IDLE, RUN, HALTED; IDLE lasts exactly one cycle after reset release, then RUN.
REQ-018 SHALL transition RUN->HALTED when halt=1; HALTED->RUN when halt=0 or redirect_valid=1.
REQ-019 SHALL hold a queue of DEPTH entries {data, pc}; DEPTH=4 with IFETCH_PREFETCH_EN, DEPTH=1 without.
REQ-020 SHALL assert ireq in RUN only when (queue occupancy + outstanding requests) < DEPTH and redirect_valid=0.
REQ-021 SHALL drive iaddr=pc_out when ireq=1 and increment pc_out by 1 modulo 2^ADDR_W per issue (24'hFFFFFF wraps to 24'h000000).
REQ-022 SHALL write idata plus its request address into the queue tail in the cycle after the matching ireq.
REQ-023 SHALL transfer the head on instr_valid=1 and instr_ready=1; instr_data/instr_pc SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-024 SHALL allow enqueue and dequeue in the same cycle when the queue is full, keeping occupancy unchanged.
REQ-025 On redirect_valid=1 SHALL: complete any head handshake that cycle, flush all other entries, drop the idata returning that cycle, force ireq=0, load pc_out<=redirect_pc; first fetch from redirect_pc issues the next cycle.
REQ-026 SHALL give redirect_valid priority over halt in the same cycle (enter RUN).
REQ-027 In HALTED SHALL still accept the in-flight response and drain the queue to decode.
REQ-028 SHALL sustain 1 instruction/cycle with IFETCH_PREFETCH_EN and 1 per 2 cycles without, when instr_ready=1.
REQ-029 SHALL produce first instr_valid=1 two cycles after IDLE exits (issue cycle, then data cycle).

Reset
REQ-030 On rst=1 SHALL asynchronously set state=IDLE, pc_out=RESET_PC, queue empty, outstanding=0, ireq=0, instr_valid=0, instr_data=0, instr_pc=0.
REQ-031 Reset asserted mid-operation SHALL discard queued and in-flight instructions; idata arriving the cycle after release SHALL be ignored.

Configuration
REQ-032 Macro IFETCH_PREFETCH_EN defined SHALL build 4-entry queue with up to 2 outstanding requests; undefined SHALL build a single holding register with 1 outstanding request; interface identical in both builds.

Structure
REQ-033 SHALL place ADDR_W/DATA_W defaults, PC register index (31) and the fetch state encoding in shared package proc_pkg.
REQ-034 SHALL implement the queue as sub-module ifetch_queue (parameterised depth, flush input).

Verification
REQ-035 Reset release, idata=addr+24'h100, instr_ready=1 -> instr_pc 0,1,2,3 with data 24'h100..24'h103, first valid 2 cycles after IDLE.
REQ-036 instr_ready=0 for 10 cycles (prefetch build) -> exactly 4 entries queued, ireq=0, head stable at pc 0; release -> 4 back-to-back transfers.
REQ-037 Redirect to 24'h000040 while 3 queued -> next valid instr_pc=24'h000040, no stale pc delivered, dropped response not enqueued.
REQ-038 RESET_PC=24'hFFFFFE -> fetch order FFFFFE, FFFFFF, 000000, 000001.
REQ-039 halt=1 at pc 5 -> ireq stays 0, queued entries drain; halt=0 -> fetch resumes at pc_out unchanged.
REQ-040 rst pulsed with queue non-empty -> instr_valid=0 immediately, restart from RESET_PC.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor widths, PC register index and fetch state encoding
package proc_pkg;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 24;
  localparam int PC_REG_IDX = 31;

  localparam logic [1:0] FETCH_IDLE   = 2'd0;
  localparam logic [1:0] FETCH_RUN    = 2'd1;
  localparam logic [1:0] FETCH_HALTED = 2'd2;
endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - shifting instruction queue of {data, pc}; head always at entry 0, flush empties it
module ifetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_push_data,
  input  logic [ADDR_W-1:0]            i_push_pc,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic [DATA_W-1:0]            o_data,
  output logic [ADDR_W-1:0]            o_pc,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic             w_deq;
  logic             w_full;
  logic             w_push;
  logic [CNT_W-1:0] w_wpos;

  assign w_deq   = i_pop && (r_count != '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push && !i_flush && (!w_full || w_deq);
  assign w_wpos  = r_count - CNT_W'(w_deq);

  assign o_valid = (r_count != '0);
  assign o_data  = r_data[0];
  assign o_pc    = r_pc[0];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_wpos == CNT_W'(i))) begin
          r_data[i] <= i_push_data;
          r_pc[i]   <= i_push_pc;
        end else if (w_deq && (i < DEPTH-1)) begin
          r_data[i] <= r_data[(i+1 < DEPTH) ? i+1 : i];
          r_pc[i]   <= r_pc[(i+1 < DEPTH) ? i+1 : i];
        end
      end
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit; IFETCH_PREFETCH_EN selects 4-entry prefetch queue, else 1-entry holding register
module ifetch_unit
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] iaddr,
  output logic              ireq,
  input  logic [DATA_W-1:0] idata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc_out
);
`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_pc;

  logic [CNT_W-1:0]  w_count;
  logic              w_deq;
  logic [3:0]        w_used;
  logic              w_issue;

  assign w_deq   = instr_valid && instr_ready;
  // Slots committed: queued + response in flight, minus the head leaving this cycle.
  assign w_used  = 4'(w_count) + 4'(r_pend) - 4'(w_deq);
  assign w_issue = (r_state == FETCH_RUN) && !redirect_valid && !halt && (w_used < 4'(DEPTH));

  assign ireq   = w_issue;
  assign iaddr  = r_pc;
  assign pc_out = r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH_IDLE;
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_pend    <= w_issue;
      r_pend_pc <= r_pc;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + 1'b1;
      end
      case (r_state)
        FETCH_IDLE:   r_state <= FETCH_RUN;
        FETCH_RUN:    if (!redirect_valid && halt) r_state <= FETCH_HALTED;
        FETCH_HALTED: if (redirect_valid || !halt) r_state <= FETCH_RUN;
        default:      r_state <= FETCH_IDLE;
      endcase
    end
  end

  ifetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect_valid),
    .i_push      (r_pend),
    .i_push_data (idata),
    .i_push_pc   (r_pend_pc),
    .i_pop       (instr_ready),
    .o_valid     (instr_valid),
    .o_data      (instr_data),
    .o_pc        (instr_pc),
    .o_count     (w_count)
  );
endmodule
